// File: rtl/irq_source_ctrl.sv
// rtl/irq_source_ctrl.sv - level/edge interrupt source controller feeding the CP0 interrupt inputs
// Synchronises device requests, latches/masks them and freezes the presented vector while exl is high.
module irq_source_ctrl #(
  parameter int NSRC        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic            exl,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic [NSRC-1:0] int_out,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] synced, sync_dly, rise;
  logic [NSRC-1:0] pending, enable, mode, snapshot;
  logic [NSRC-1:0] req, w1c, int_nx, snap_nx;
  logic            exl_q, exl_rise, exl_fall;
  logic [2:0]      snap_idx;
  logic            wd_unused;

  assign wd_unused = ^wd[31:NSRC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      sync_dly <= '0;
    end else begin
      sync_q[0] <= src_irq;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      sync_dly <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~sync_dly;
  assign w1c    = (we && addr == 2'd0) ? wd[NSRC-1:0] : '0;
  assign req    = pending & enable;

  // Edge bits: a same-cycle rising edge beats the W1C; level bits just follow the synced line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      exl_q   <= 1'b0;
    end else begin
      pending <= (mode & ((pending & ~w1c) | rise)) | (~mode & synced);
      if (we && addr == 2'd1) enable <= wd[NSRC-1:0];
      if (we && addr == 2'd2) mode   <= wd[NSRC-1:0];
      exl_q <= exl;
    end
  end

  assign exl_rise = exl & ~exl_q;
  assign exl_fall = ~exl & exl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      int_out  <= '0;
      snapshot <= '0;
    end else begin
      state    <= state_nx;
      int_out  <= int_nx;
      snapshot <= snap_nx;
    end
  end

  always_comb begin
    state_nx = state;
    int_nx   = int_out;
    snap_nx  = snapshot;
    case (state)
      IDLE: begin
        int_nx = req;
        if (|req) state_nx = ASSERT;
      end
      ASSERT: begin
        if (exl_rise) begin
          snap_nx  = int_out;
          state_nx = SERVICE;
        end else begin
          int_nx = req;
          if (!(|req) && !exl) state_nx = IDLE;
        end
      end
      SERVICE: begin
        // Presented vector stays frozen until the handler leaves exception level.
        if (exl_fall) begin
          int_nx   = req;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SERVICE);

  always_comb begin
    snap_idx = 3'd7;
    for (int i = 0; i < NSRC; i++) begin
      if (snapshot[i]) snap_idx = i[2:0];
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: rd[NSRC-1:0] = pending;
      2'd1: rd[NSRC-1:0] = enable;
      2'd2: rd[NSRC-1:0] = mode;
      default: begin
        rd[2:0]        = snap_idx;
        rd[8]          = busy;
        rd[16 +: NSRC] = snapshot;
      end
    endcase
  end

endmodule
